// File: rtl/riscv_hazard_ctrl.sv
// Hazard controller for a 5-stage RV32I pipe: E-stage forwarding, load-use stall,
// branch redirect flush, data-memory freeze with timeout watchdog, perf counters.
module riscv_hazard_ctrl #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [4:0]      i_rs1_d,
  input  logic [4:0]      i_rs2_d,
  input  logic [4:0]      i_rs1_e,
  input  logic [4:0]      i_rs2_e,
  input  logic [4:0]      i_rd_e,
  input  logic [1:0]      i_result_src_e,
  input  logic            i_pc_src_e,
  input  logic [4:0]      i_rd_m,
  input  logic            i_reg_write_m,
  input  logic [4:0]      i_rd_w,
  input  logic            i_reg_write_w,
  input  logic            i_dmem_req_m,
  input  logic            i_dmem_ready,
  output logic [1:0]      o_forward_a_e,
  output logic [1:0]      o_forward_b_e,
  output logic            o_stall_f,
  output logic            o_stall_d,
  output logic            o_stall_e,
  output logic            o_stall_m,
  output logic            o_flush_d,
  output logic            o_flush_e,
  output logic            o_flush_w,
  output logic            o_mem_timeout,
  output logic [XLEN-1:0] o_stall_cnt,
  output logic [XLEN-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_ERR     = 2'd2
  } state_t;

  localparam logic [15:0]     TMO_LIM = 16'(MEM_TIMEOUT);
  localparam logic [XLEN-1:0] CNT_ONE = {{(XLEN-1){1'b0}}, 1'b1};

  state_t            state_r, state_nxt_s;
  logic [15:0]       tmo_cnt_r, tmo_nxt_s;
  logic              mem_timeout_r;
  logic [XLEN-1:0]   stall_cnt_r, flush_cnt_r;
  logic              lwstall_s, memstall_s, flush_ev_s;
  logic              stall_f_s, stall_d_s, stall_e_s, stall_m_s;
  logic              flush_d_s, flush_e_s, flush_w_s;

  // Forwarding selects; the younger producer in M wins over W.
  always_comb begin
    o_forward_a_e = 2'b00;
    o_forward_b_e = 2'b00;
    if (i_rs1_e != 5'd0 && i_rs1_e == i_rd_m && i_reg_write_m) begin
      o_forward_a_e = 2'b10;
    end else if (i_rs1_e != 5'd0 && i_rs1_e == i_rd_w && i_reg_write_w) begin
      o_forward_a_e = 2'b01;
    end else begin
      o_forward_a_e = 2'b00;
    end
    if (i_rs2_e != 5'd0 && i_rs2_e == i_rd_m && i_reg_write_m) begin
      o_forward_b_e = 2'b10;
    end else if (i_rs2_e != 5'd0 && i_rs2_e == i_rd_w && i_reg_write_w) begin
      o_forward_b_e = 2'b01;
    end else begin
      o_forward_b_e = 2'b00;
    end
  end

  assign lwstall_s  = (i_result_src_e == 2'b01) && (i_rd_e != 5'd0) &&
                      ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));
  assign memstall_s = i_dmem_req_m && !i_dmem_ready;

  // Next-state, watchdog and stall/flush decode.
  always_comb begin
    state_nxt_s = state_r;
    tmo_nxt_s   = tmo_cnt_r;
    flush_ev_s  = 1'b0;
    stall_f_s   = 1'b0;
    stall_d_s   = 1'b0;
    stall_e_s   = 1'b0;
    stall_m_s   = 1'b0;
    flush_d_s   = 1'b0;
    flush_e_s   = 1'b0;
    flush_w_s   = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (memstall_s) begin
          {stall_f_s, stall_d_s, stall_e_s, stall_m_s, flush_w_s} = 5'b11111;
          state_nxt_s = ST_MEMWAIT;
          tmo_nxt_s   = 16'd1;
        end else if (i_pc_src_e) begin
          flush_d_s  = 1'b1;
          flush_e_s  = 1'b1;
          flush_ev_s = 1'b1;
        end else if (lwstall_s) begin
          stall_f_s = 1'b1;
          stall_d_s = 1'b1;
          flush_e_s = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_MEMWAIT: begin
        if (!i_dmem_ready) begin
          {stall_f_s, stall_d_s, stall_e_s, stall_m_s, flush_w_s} = 5'b11111;
          if (tmo_cnt_r >= TMO_LIM) begin
            state_nxt_s = ST_ERR;
          end else begin
            tmo_nxt_s = tmo_cnt_r + 16'd1;
          end
        end else begin
          state_nxt_s = ST_RUN;
          tmo_nxt_s   = 16'd0;
        end
      end
      ST_ERR: begin
        {stall_f_s, stall_d_s, stall_e_s, stall_m_s, flush_w_s} = 5'b11111;
      end
      default: begin
        state_nxt_s = ST_RUN;
        tmo_nxt_s   = 16'd0;
      end
    endcase
  end

  // State, watchdog counter and sticky timeout flag.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r       <= ST_RUN;
      tmo_cnt_r     <= 16'd0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      tmo_cnt_r <= tmo_nxt_s;
      if (state_nxt_s == ST_ERR) begin
        mem_timeout_r <= 1'b1;
      end else begin
        mem_timeout_r <= mem_timeout_r;
      end
    end
  end

  // Performance counters, wrapping naturally.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stall_cnt_r <= {XLEN{1'b0}};
      flush_cnt_r <= {XLEN{1'b0}};
    end else begin
      if (stall_f_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_ev_s) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign o_stall_f     = stall_f_s;
  assign o_stall_d     = stall_d_s;
  assign o_stall_e     = stall_e_s;
  assign o_stall_m     = stall_m_s;
  assign o_flush_d     = flush_d_s;
  assign o_flush_e     = flush_e_s;
  assign o_flush_w     = flush_w_s;
  assign o_mem_timeout = mem_timeout_r;
  assign o_stall_cnt   = stall_cnt_r;
  assign o_flush_cnt   = flush_cnt_r;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed bench for riscv_hazard_ctrl (MEM_TIMEOUT=8): forwarding, load-use,
// redirect, memory wait, watchdog timeout and asynchronous reset.
module tb_riscv_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0]  result_src_e;
  logic        pc_src_e, reg_write_m, reg_write_w, dmem_req_m, dmem_ready;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  riscv_hazard_ctrl #(.XLEN(32), .MEM_TIMEOUT(8)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e(rs1_e), .i_rs2_e(rs2_e),
    .i_rd_e(rd_e), .i_result_src_e(result_src_e), .i_pc_src_e(pc_src_e),
    .i_rd_m(rd_m), .i_reg_write_m(reg_write_m), .i_rd_w(rd_w), .i_reg_write_w(reg_write_w),
    .i_dmem_req_m(dmem_req_m), .i_dmem_ready(dmem_ready),
    .o_forward_a_e(fwd_a), .o_forward_b_e(fwd_b),
    .o_stall_f(stall_f), .o_stall_d(stall_d), .o_stall_e(stall_e), .o_stall_m(stall_m),
    .o_flush_d(flush_d), .o_flush_e(flush_e), .o_flush_w(flush_w),
    .o_mem_timeout(mem_timeout), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0;
    rd_m = 5'd0; rd_w = 5'd0; result_src_e = 2'b00; pc_src_e = 1'b0;
    reg_write_m = 1'b0; reg_write_w = 1'b0; dmem_req_m = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rstn = 1'b0;
    #3;
    step();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000000", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w});
    end
    checks++;
    if ({mem_timeout, stall_cnt, flush_cnt} !== 65'd0) begin
      failures++;
      $display("FAIL reset_regs got tmo=%b sc=%0d fc=%0d exp all 0", mem_timeout, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_forward();
    rd_m = 5'd5; reg_write_m = 1'b1; rs1_e = 5'd5; rs2_e = 5'd5;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b1010) begin
      failures++; $display("FAIL fwd_m got=%b exp=1010", {fwd_a, fwd_b});
    end
    reg_write_m = 1'b0; rd_m = 5'd0; rd_w = 5'd5; reg_write_w = 1'b1;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0101) begin
      failures++; $display("FAIL fwd_w got=%b exp=0101", {fwd_a, fwd_b});
    end
    rd_m = 5'd5; reg_write_m = 1'b1; rs2_e = 5'd6; rd_w = 5'd6;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b1001) begin
      failures++; $display("FAIL fwd_prio got=%b exp=1001", {fwd_a, fwd_b});
    end
    rs1_e = 5'd0; rs2_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      failures++; $display("FAIL fwd_x0 got=%b exp=0000", {fwd_a, fwd_b});
    end
    set_idle();
    #1;
  endtask

  task automatic test_load_use();
    result_src_e = 2'b01; rd_e = 5'd0; rs1_d = 5'd0;
    #1;
    checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b000) begin
      failures++; $display("FAIL lw_rd0 got=%b exp=000", {stall_f, stall_d, flush_e});
    end
    rd_e = 5'd7; rs1_d = 5'd3; rs2_d = 5'd7;
    #1;
    checks++;
    if ({stall_f, stall_d, stall_e, flush_d, flush_e} !== 5'b11001) begin
      failures++; $display("FAIL lw_stall got=%b exp=11001", {stall_f, stall_d, stall_e, flush_d, flush_e});
    end
    step();
    // Load has moved to M; the consumer now sits in E.
    result_src_e = 2'b00; rd_e = 5'd0; rd_m = 5'd7; reg_write_m = 1'b1; rs2_e = 5'd7; rs2_d = 5'd0;
    #1;
    checks++;
    if ({stall_f, stall_d, flush_e, fwd_b} !== 5'b00010) begin
      failures++; $display("FAIL lw_after got=%b exp=00010", {stall_f, stall_d, flush_e, fwd_b});
    end
    checks++;
    if (stall_cnt !== 32'd1) begin
      failures++; $display("FAIL lw_cnt got=%0d exp=1", stall_cnt);
    end
    set_idle();
    step();
  endtask

  task automatic test_redirect_lw();
    result_src_e = 2'b01; rd_e = 5'd9; rs1_d = 5'd9; pc_src_e = 1'b1;
    #1;
    checks++;
    if ({flush_d, flush_e, stall_f, stall_d} !== 4'b1100) begin
      failures++; $display("FAIL redir got=%b exp=1100", {flush_d, flush_e, stall_f, stall_d});
    end
    step();
    set_idle();
    #1;
    checks++;
    if ({flush_cnt, stall_cnt} !== {32'd1, 32'd1}) begin
      failures++; $display("FAIL redir_cnt got fc=%0d sc=%0d exp fc=1 sc=1", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_memwait();
    do_reset();
    dmem_req_m = 1'b1; dmem_ready = 1'b0; pc_src_e = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e} !== 7'b1111100) begin
        failures++;
        $display("FAIL memwait_c%0d got=%b exp=1111100", i, {stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e});
      end
      step();
    end
    dmem_ready = 1'b1;
    #1;
    checks++;
    if ({stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e} !== 7'b0000000) begin
      failures++; $display("FAIL memwait_rdy got=%b exp=0000000", {stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e});
    end
    step();
    dmem_req_m = 1'b0;
    #1;
    checks++;
    if ({flush_d, flush_e, stall_f} !== 3'b110) begin
      failures++; $display("FAIL memwait_redir got=%b exp=110", {flush_d, flush_e, stall_f});
    end
    step();
    pc_src_e = 1'b0;
    checks++;
    if ({stall_cnt, flush_cnt} !== {32'd4, 32'd1}) begin
      failures++; $display("FAIL memwait_cnt got sc=%0d fc=%0d exp sc=4 fc=1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req_m = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (mem_timeout !== 1'b0) begin
      failures++; $display("FAIL tmo_early got=%b exp=0", mem_timeout);
    end
    step();
    checks++;
    if ({mem_timeout, stall_cnt} !== {1'b1, 32'd9}) begin
      failures++; $display("FAIL tmo_err got tmo=%b sc=%0d exp tmo=1 sc=9", mem_timeout, stall_cnt);
    end
    dmem_ready = 1'b1; dmem_req_m = 1'b0;
    step();
    step();
    checks++;
    if ({mem_timeout, stall_f, stall_d, stall_e, stall_m, flush_w} !== 6'b111111) begin
      failures++; $display("FAIL tmo_latched got=%b exp=111111", {mem_timeout, stall_f, stall_d, stall_e, stall_m, flush_w});
    end
  endtask

  task automatic test_async_reset();
    // Still in ERR from the previous test; reset lands mid-cycle.
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({mem_timeout, stall_f, flush_w, stall_cnt, flush_cnt} !== 67'd0) begin
      failures++; $display("FAIL arst_err got tmo=%b sf=%b fw=%b sc=%0d fc=%0d exp all 0", mem_timeout, stall_f, flush_w, stall_cnt, flush_cnt);
    end
    step();
    rstn = 1'b1;
    dmem_req_m = 1'b1; dmem_ready = 1'b0; pc_src_e = 1'b1;
    step();
    step();
    dmem_req_m = 1'b0;
    #1;
    checks++;
    if ({stall_f, flush_d} !== 2'b10) begin
      failures++; $display("FAIL arst_pre got=%b exp=10", {stall_f, flush_d});
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({stall_f, stall_m, flush_w, flush_d, flush_e, mem_timeout, stall_cnt, flush_cnt} !== {6'b000110, 64'd0}) begin
      failures++; $display("FAIL arst_wait got sf=%b sm=%b fw=%b fd=%b fe=%b tmo=%b sc=%0d fc=%0d exp 000110 sc=0 fc=0",
                           stall_f, stall_m, flush_w, flush_d, flush_e, mem_timeout, stall_cnt, flush_cnt);
    end
    set_idle();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    set_idle();
    rstn = 1'b0;
    test_reset();
    test_forward();
    test_load_use();
    test_redirect_lw();
    test_memwait();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
